// File: rtl/mem_grant_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_grant_arbiter_if : exec-port request bus plus D-cache channel
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_grant_arbiter_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64
);
   logic                        i_flush;
   logic [NUM_PORTS-1:0]        i_port_ready;
   logic [NUM_PORTS*ADDR_W-1:0] i_port_addr;
   logic [NUM_PORTS*DATA_W-1:0] i_port_wdata;
   logic [NUM_PORTS-1:0]        i_port_we;
   logic [NUM_PORTS*2-1:0]      i_port_size;
   logic [NUM_PORTS-1:0]        o_port_grant;
   logic                        o_dc_req;
   logic [ADDR_W-1:0]           o_dc_addr;
   logic [DATA_W-1:0]           o_dc_wdata;
   logic                        o_dc_we;
   logic [1:0]                  o_dc_size;
   logic                        i_dc_ack;
   logic                        i_dc_resp_valid;
   logic [DATA_W-1:0]           i_dc_resp_data;
   logic                        i_dc_resp_err;
   logic                        o_resp_valid;
   logic [NUM_PORTS-1:0]        o_resp_port;
   logic [DATA_W-1:0]           o_resp_data;
   logic                        o_resp_err;
   logic                        o_busy;

   // Arbiter side
   modport slave (
      input  i_flush, i_port_ready, i_port_addr, i_port_wdata, i_port_we, i_port_size,
      input  i_dc_ack, i_dc_resp_valid, i_dc_resp_data, i_dc_resp_err,
      output o_port_grant, o_dc_req, o_dc_addr, o_dc_wdata, o_dc_we, o_dc_size,
      output o_resp_valid, o_resp_port, o_resp_data, o_resp_err, o_busy
   );

   // Exec ports / D-cache side
   modport master (
      output i_flush, i_port_ready, i_port_addr, i_port_wdata, i_port_we, i_port_size,
      output i_dc_ack, i_dc_resp_valid, i_dc_resp_data, i_dc_resp_err,
      input  o_port_grant, o_dc_req, o_dc_addr, o_dc_wdata, o_dc_we, o_dc_size,
      input  o_resp_valid, o_resp_port, o_resp_data, o_resp_err, o_busy
   );
endinterface

`default_nettype wire

// File: rtl/mem_grant_arbiter.sv
//------------------------------------------------------------------------------
// mem_grant_arbiter : round-robin exec-port arbiter onto one D-cache channel
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_grant_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst_n,
   mem_grant_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_PORTS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]           state, state_nxt;
   logic [PTR_W-1:0]     rr_ptr, rr_nxt;
   logic [PTR_W-1:0]     idx_hi, idx_lo, win_idx;
   logic                 found_hi, found_lo;
   logic                 take, dc_req, busy;
   logic [NUM_PORTS-1:0] grant, txn_port, resp_port;
   logic [ADDR_W-1:0]    sel_addr, dc_addr;
   logic [DATA_W-1:0]    sel_wdata, dc_wdata, resp_data;
   logic                 sel_we, dc_we, resp_valid, resp_err;
   logic [1:0]           sel_size, dc_size;

   // Winner: first ready at or above rr_ptr, otherwise wrap to lowest ready port
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (!found_hi && bus.i_port_ready[p] && (PTR_W'(p) >= rr_ptr)) begin
            found_hi = 1'b1;
            idx_hi   = PTR_W'(p);
         end
         if (!found_lo && bus.i_port_ready[p]) begin
            found_lo = 1'b1;
            idx_lo   = PTR_W'(p);
         end
      end
      win_idx = found_hi ? idx_hi : idx_lo;
      rr_nxt  = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + PTR_W'(1);
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found_lo && !bus.i_flush) state_nxt = S_REQ;
         S_REQ: begin
            if (bus.i_flush)       state_nxt = bus.i_dc_ack ? S_DRAIN : S_IDLE;
            else if (bus.i_dc_ack) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.i_flush)              state_nxt = bus.i_dc_resp_valid ? S_IDLE : S_DRAIN;
            else if (bus.i_dc_resp_valid) state_nxt = S_IDLE;
         end
         default: if (bus.i_dc_resp_valid) state_nxt = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      take   = (state == S_IDLE) && found_lo && !bus.i_flush;
      dc_req = (state == S_REQ);
      busy   = (state != S_IDLE);
      grant  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         grant[p] = take && (win_idx == PTR_W'(p));
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      sel_size  = 2'd0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_addr  = bus.i_port_addr[p*ADDR_W +: ADDR_W];
            sel_wdata = bus.i_port_wdata[p*DATA_W +: DATA_W];
            sel_we    = bus.i_port_we[p];
            sel_size  = bus.i_port_size[p*2 +: 2];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rr_ptr     <= '0;
         txn_port   <= '0;
         dc_addr    <= '0;
         dc_wdata   <= '0;
         dc_we      <= 1'b0;
         dc_size    <= 2'd0;
         resp_valid <= 1'b0;
         resp_port  <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         if (take) begin
            rr_ptr   <= rr_nxt;
            txn_port <= grant;
            dc_addr  <= sel_addr;
            dc_wdata <= sel_wdata;
            dc_we    <= sel_we;
            dc_size  <= sel_size;
         end
         // Responses only leave from WAIT; stray pulses in other states are dropped
         if ((state == S_WAIT) && bus.i_dc_resp_valid && !bus.i_flush) begin
            resp_valid <= 1'b1;
            resp_port  <= txn_port;
            resp_data  <= bus.i_dc_resp_data;
            resp_err   <= bus.i_dc_resp_err;
         end
      end
   end

   assign bus.o_port_grant = grant;
   assign bus.o_dc_req     = dc_req;
   assign bus.o_dc_addr    = dc_addr;
   assign bus.o_dc_wdata   = dc_wdata;
   assign bus.o_dc_we      = dc_we;
   assign bus.o_dc_size    = dc_size;
   assign bus.o_resp_valid = resp_valid;
   assign bus.o_resp_port  = resp_port;
   assign bus.o_resp_data  = resp_data;
   assign bus.o_resp_err   = resp_err;
   assign bus.o_busy       = busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_grant_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_grant_arbiter : directed self-checking bench for mem_grant_arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_grant_arbiter;
   localparam int NUM_PORTS = 2;
   localparam int ADDR_W    = 64;
   localparam int DATA_W    = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [1:0] exp_g [4];

   always #5 clk = ~clk;

   mem_grant_arbiter_if #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_grant_arbiter #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n               = 1'b0;
      bus.i_flush         = 1'b0;
      bus.i_port_ready    = '0;
      bus.i_port_addr     = '0;
      bus.i_port_wdata    = '0;
      bus.i_port_we       = '0;
      bus.i_port_size     = '0;
      bus.i_dc_ack        = 1'b0;
      bus.i_dc_resp_valid = 1'b0;
      bus.i_dc_resp_data  = '0;
      bus.i_dc_resp_err   = 1'b0;
      cyc();
      cyc();
      #1;
      chk("rst_busy",   64'(bus.o_busy), 64'd0);
      chk("rst_dcreq",  64'(bus.o_dc_req), 64'd0);
      chk("rst_grant",  64'(bus.o_port_grant), 64'd0);
      chk("rst_rvalid", 64'(bus.o_resp_valid), 64'd0);
      chk("rst_addr",   64'(bus.o_dc_addr), 64'd0);
      chk("rst_rdata",  64'(bus.o_resp_data), 64'd0);
      rst_n = 1'b1;
      cyc();

      // Port0 load, minimum latency
      bus.i_port_ready = 2'b01;
      bus.i_port_addr[0 +: 64] = 64'h1000;
      bus.i_port_size[1:0] = 2'd3;
      #1;
      chk("t1_grant", 64'(bus.o_port_grant), 64'h1);
      cyc();
      bus.i_port_ready = 2'b00;
      bus.i_dc_ack = 1'b1;
      #1;
      chk("t1_dcreq", 64'(bus.o_dc_req), 64'd1);
      chk("t1_addr",  64'(bus.o_dc_addr), 64'h1000);
      chk("t1_size",  64'(bus.o_dc_size), 64'd3);
      chk("t1_we",    64'(bus.o_dc_we), 64'd0);
      cyc();
      bus.i_dc_ack = 1'b0;
      bus.i_dc_resp_valid = 1'b1;
      bus.i_dc_resp_data = 64'hDEADBEEF;
      #1;
      chk("t1_wait_dcreq", 64'(bus.o_dc_req), 64'd0);
      chk("t1_wait_busy",  64'(bus.o_busy), 64'd1);
      cyc();
      bus.i_dc_resp_valid = 1'b0;
      #1;
      chk("t1_rvalid", 64'(bus.o_resp_valid), 64'd1);
      chk("t1_rport",  64'(bus.o_resp_port), 64'h1);
      chk("t1_rdata",  64'(bus.o_resp_data), 64'hDEADBEEF);
      chk("t1_rerr",   64'(bus.o_resp_err), 64'd0);
      chk("t1_idle",   64'(bus.o_busy), 64'd0);
      cyc();
      chk("t1_rvalid_drop", 64'(bus.o_resp_valid), 64'd0);
      chk("t1_rdata_hold",  64'(bus.o_resp_data), 64'hDEADBEEF);

      // Both ports ready: pointer sits at 1 after the port0 transaction
      exp_g[0] = 2'b10;
      exp_g[1] = 2'b01;
      exp_g[2] = 2'b10;
      exp_g[3] = 2'b01;
      bus.i_port_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t2_grant%0d", i), 64'(bus.o_port_grant), 64'(exp_g[i]));
         cyc();
         bus.i_dc_ack = 1'b1;
         #1;
         chk($sformatf("t2_req_nogrant%0d", i), 64'(bus.o_port_grant), 64'd0);
         cyc();
         bus.i_dc_ack = 1'b0;
         bus.i_dc_resp_valid = 1'b1;
         bus.i_dc_resp_data = 64'(i + 16);
         cyc();
         bus.i_dc_resp_valid = 1'b0;
         #1;
         chk($sformatf("t2_rport%0d", i), 64'(bus.o_resp_port), 64'(exp_g[i]));
         chk($sformatf("t2_rdata%0d", i), 64'(bus.o_resp_data), 64'(i + 16));
      end
      bus.i_port_ready = 2'b00;
      cyc();

      // Port1 store with ack held low three cycles
      bus.i_port_ready = 2'b10;
      bus.i_port_addr[64 +: 64] = 64'h2008;
      bus.i_port_wdata[64 +: 64] = 64'h55;
      bus.i_port_we = 2'b10;
      bus.i_port_size[3:2] = 2'd2;
      #1;
      chk("t3_grant", 64'(bus.o_port_grant), 64'h2);
      cyc();
      bus.i_port_ready = 2'b00;
      bus.i_port_addr[64 +: 64] = 64'hFFFF;
      bus.i_port_wdata[64 +: 64] = 64'hAA;
      for (int k = 0; k < 4; k++) begin
         bus.i_dc_ack = (k == 3);
         #1;
         chk($sformatf("t3_req%0d", k),   64'(bus.o_dc_req), 64'd1);
         chk($sformatf("t3_addr%0d", k),  64'(bus.o_dc_addr), 64'h2008);
         chk($sformatf("t3_wdata%0d", k), 64'(bus.o_dc_wdata), 64'h55);
         chk($sformatf("t3_we%0d", k),    64'(bus.o_dc_we), 64'd1);
         cyc();
      end
      bus.i_dc_ack = 1'b0;
      #1;
      chk("t3_wait_req",  64'(bus.o_dc_req), 64'd0);
      chk("t3_wait_busy", 64'(bus.o_busy), 64'd1);
      bus.i_dc_resp_valid = 1'b1;
      bus.i_dc_resp_data = 64'h0;
      cyc();
      bus.i_dc_resp_valid = 1'b0;
      #1;
      chk("t3_rvalid", 64'(bus.o_resp_valid), 64'd1);
      chk("t3_rport",  64'(bus.o_resp_port), 64'h2);
      cyc();

      // Flush in REQ before ack
      bus.i_port_ready = 2'b01;
      bus.i_port_addr[0 +: 64] = 64'h3000;
      #1;
      chk("t4_grant", 64'(bus.o_port_grant), 64'h1);
      cyc();
      bus.i_port_ready = 2'b00;
      #1;
      chk("t4_req", 64'(bus.o_dc_req), 64'd1);
      bus.i_flush = 1'b1;
      cyc();
      bus.i_flush = 1'b0;
      #1;
      chk("t4_flush_req",  64'(bus.o_dc_req), 64'd0);
      chk("t4_flush_idle", 64'(bus.o_busy), 64'd0);

      // Flush in WAIT, response arrives two cycles later and is discarded
      bus.i_port_ready = 2'b01;
      #1;
      chk("t5_grant_wrap", 64'(bus.o_port_grant), 64'h1);
      cyc();
      bus.i_port_ready = 2'b00;
      bus.i_dc_ack = 1'b1;
      cyc();
      bus.i_dc_ack = 1'b0;
      bus.i_flush = 1'b1;
      cyc();
      bus.i_flush = 1'b0;
      #1;
      chk("t5_drain_busy", 64'(bus.o_busy), 64'd1);
      chk("t5_drain_rv0",  64'(bus.o_resp_valid), 64'd0);
      cyc();
      chk("t5_drain_rv1",  64'(bus.o_resp_valid), 64'd0);
      bus.i_dc_resp_valid = 1'b1;
      bus.i_dc_resp_data = 64'h77;
      cyc();
      bus.i_dc_resp_valid = 1'b0;
      #1;
      chk("t5_drain_rv2", 64'(bus.o_resp_valid), 64'd0);
      chk("t5_idle",      64'(bus.o_busy), 64'd0);
      chk("t5_rdata",     64'(bus.o_resp_data), 64'h0);

      // Flush blocks grants in IDLE
      bus.i_port_ready = 2'b01;
      bus.i_flush = 1'b1;
      #1;
      chk("t5_flush_nogrant", 64'(bus.o_port_grant), 64'd0);
      cyc();
      bus.i_flush = 1'b0;
      bus.i_port_ready = 2'b00;
      #1;
      chk("t5_flush_stay_idle", 64'(bus.o_busy), 64'd0);

      // Reset during WAIT (pointer is 1 beforehand)
      bus.i_port_ready = 2'b10;
      #1;
      chk("t6_grant", 64'(bus.o_port_grant), 64'h2);
      cyc();
      bus.i_port_ready = 2'b00;
      bus.i_dc_ack = 1'b1;
      cyc();
      bus.i_dc_ack = 1'b0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      #1;
      chk("t6_busy",  64'(bus.o_busy), 64'd0);
      chk("t6_req",   64'(bus.o_dc_req), 64'd0);
      chk("t6_addr",  64'(bus.o_dc_addr), 64'd0);
      chk("t6_wdata", 64'(bus.o_dc_wdata), 64'd0);
      chk("t6_we",    64'(bus.o_dc_we), 64'd0);
      chk("t6_size",  64'(bus.o_dc_size), 64'd0);
      chk("t6_rv",    64'(bus.o_resp_valid), 64'd0);
      chk("t6_rport", 64'(bus.o_resp_port), 64'd0);
      chk("t6_rdata", 64'(bus.o_resp_data), 64'd0);
      chk("t6_grant0", 64'(bus.o_port_grant), 64'd0);
      bus.i_port_ready = 2'b11;
      #1;
      chk("t6_first_grant", 64'(bus.o_port_grant), 64'h1);

      // Access fault response
      cyc();
      bus.i_port_ready = 2'b00;
      bus.i_dc_ack = 1'b1;
      cyc();
      bus.i_dc_ack = 1'b0;
      bus.i_dc_resp_valid = 1'b1;
      bus.i_dc_resp_err = 1'b1;
      bus.i_dc_resp_data = 64'hBAD;
      cyc();
      bus.i_dc_resp_valid = 1'b0;
      bus.i_dc_resp_err = 1'b0;
      #1;
      chk("t7_rv",    64'(bus.o_resp_valid), 64'd1);
      chk("t7_err",   64'(bus.o_resp_err), 64'd1);
      chk("t7_rport", 64'(bus.o_resp_port), 64'h1);
      chk("t7_rdata", 64'(bus.o_resp_data), 64'hBAD);

      // Stray response in IDLE is ignored
      bus.i_dc_resp_valid = 1'b1;
      bus.i_dc_resp_data = 64'h99;
      cyc();
      bus.i_dc_resp_valid = 1'b0;
      #1;
      chk("t8_stray_rv",   64'(bus.o_resp_valid), 64'd0);
      chk("t8_stray_data", 64'(bus.o_resp_data), 64'hBAD);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
